// File: rtl/nb_frc_acc_scheduler_if.sv
// ---------------------------------------------------------------------------
// nb_frc_acc_scheduler_if
//   Bundles the per-filter force-fragment request side, the flush handshake
//   and the accumulator issue bus of the neighbour-force accumulator
//   scheduler.
//
//   master : upstream side (filters / phase control); drives requests and
//            flush_req, observes grants, status and the accumulator bus.
//   slave  : the scheduler itself.
//
//   req_valid/req_frc/req_last  per-filter fragment stream
//   req_ready                   one-hot grant back to the filters
//   flush_req/flush_done/busy   end-of-phase flush handshake
//   nb_frc_valid/nb_frc         fragment issued to the accumulator
//   nb_reg_sel                  one-hot accumulator register select
//   nb_reg_release_flag         release the selected register
// ---------------------------------------------------------------------------
interface nb_frc_acc_scheduler_if #(
   parameter int NUM_FILTERS          = 4,
   parameter int FRC_PKT_STRUCT_WIDTH = 48
);
   logic [NUM_FILTERS-1:0]                           req_valid;
   logic [NUM_FILTERS-1:0][FRC_PKT_STRUCT_WIDTH-1:0] req_frc;
   logic [NUM_FILTERS-1:0]                           req_last;
   logic [NUM_FILTERS-1:0]                           req_ready;
   logic                                             flush_req;
   logic                                             flush_done;
   logic                                             busy;
   logic                                             nb_frc_valid;
   logic [FRC_PKT_STRUCT_WIDTH-1:0]                  nb_frc;
   logic [NUM_FILTERS-1:0]                           nb_reg_sel;
   logic                                             nb_reg_release_flag;

   modport master (
      output req_valid, req_frc, req_last, flush_req,
      input  req_ready, flush_done, busy,
      input  nb_frc_valid, nb_frc, nb_reg_sel, nb_reg_release_flag
   );

   modport slave (
      input  req_valid, req_frc, req_last, flush_req,
      output req_ready, flush_done, busy,
      output nb_frc_valid, nb_frc, nb_reg_sel, nb_reg_release_flag
   );
endinterface

// File: rtl/nb_frc_acc_scheduler.sv
// ---------------------------------------------------------------------------
// nb_frc_acc_scheduler
//   Round-robin arbiter in front of the per-filter partial force accumulator.
//   One issue per cycle at most; each filter's accumulator register is locked
//   for ACC_LATENCY cycles after an issue so the adder result is written back
//   before the register is touched again. Tracks which registers hold an open
//   (unreleased) partial sum and the particle tag it belongs to, and emits
//   release flags on the last fragment, on a particle change (implicit close)
//   and during an end-of-phase flush.
//
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset (also resets the accumulator)
//     bus  nb_frc_acc_scheduler_if.slave: request streams, flush handshake,
//          registered accumulator issue bus
//
//   nb_frc_acc_lane (below) holds the per-register state: lockout counter,
//   dirty bit and stored tag.
// ---------------------------------------------------------------------------

// Per-register lane: lockout counter, dirty flag, stored particle tag.
//   clk_i/rst_i  clock, synchronous reset
//   issue_i      this register is issued to this cycle (data or release)
//   release_i    the issue closes the register
//   tag_i        tag of the fragment being issued (stored on open issues)
//   idle_o       lock counter is zero, register may be issued
//   dirty_o      register holds an open partial sum
//   tag_o        tag of the open partial sum
module nb_frc_acc_lane #(
   parameter int ACC_LATENCY = 3,
   parameter int TAG_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_i,
   input  logic             release_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             idle_o,
   output logic             dirty_o,
   output logic [TAG_W-1:0] tag_o
);
   localparam int LW = $clog2(ACC_LATENCY + 1);

   logic [LW-1:0]    lock_q, lock_d;
   logic             dirty_q, dirty_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   always_comb begin
      lock_d  = lock_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      if (issue_i) begin
         lock_d = LW'(ACC_LATENCY);
         if (release_i) begin
            dirty_d = 1'b0;
         end else begin
            dirty_d = 1'b1;
            tag_d   = tag_i;
         end
      end else if (lock_q != '0) begin
         lock_d = lock_q - LW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q  <= '0;
         dirty_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         lock_q  <= lock_d;
         dirty_q <= dirty_d;
         tag_q   <= tag_d;
      end
   end

   assign idle_o  = (lock_q == '0);
   assign dirty_o = dirty_q;
   assign tag_o   = tag_q;
endmodule

module nb_frc_acc_scheduler #(
   parameter int NUM_FILTERS          = 4,
   parameter int ACC_LATENCY          = 3,
   parameter int FRC_PKT_STRUCT_WIDTH = 48,
   parameter int FLOAT_STRUCT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   nb_frc_acc_scheduler_if.slave bus
);
   localparam int TAG_W = FRC_PKT_STRUCT_WIDTH - FLOAT_STRUCT_WIDTH;
   localparam int IW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int CW    = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e                          state_q, state_d;
   logic [IW-1:0]                   ptr_q, ptr_d;
   logic [CW-1:0]                   cnt_q, cnt_d;

   // Registered accumulator bus
   logic                            vld_q, vld_d;
   logic [FRC_PKT_STRUCT_WIDTH-1:0] frc_q, frc_d;
   logic [NUM_FILTERS-1:0]          sel_q, sel_d;
   logic                            rel_q, rel_d;
   logic                            done_q, done_d;

   // Lane interface
   logic [NUM_FILTERS-1:0]             lane_issue, lane_rel;
   logic [NUM_FILTERS-1:0]             lock_zero, dirty;
   logic [NUM_FILTERS-1:0][TAG_W-1:0]  tag, in_tag;

   logic [NUM_FILTERS-1:0]          rdy_c;
   logic [NUM_FILTERS-1:0]          elig;
   logic                            grant_found;
   logic [IW-1:0]                   grant_idx;
   logic                            fl_found;
   logic [IW-1:0]                   fl_idx;

   always_comb begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
         in_tag[i] = bus.req_frc[i][FRC_PKT_STRUCT_WIDTH-1:FLOAT_STRUCT_WIDTH];
      end
   end

   for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_lane
      nb_frc_acc_lane #(
         .ACC_LATENCY (ACC_LATENCY),
         .TAG_W       (TAG_W)
      ) u_lane (
         .clk_i     (clk),
         .rst_i     (rst),
         .issue_i   (lane_issue[i]),
         .release_i (lane_rel[i]),
         .tag_i     (in_tag[i]),
         .idle_o    (lock_zero[i]),
         .dirty_o   (dirty[i]),
         .tag_o     (tag[i])
      );
   end

   assign elig = bus.req_valid & lock_zero;

   // Round-robin: first eligible index at or after the pointer, wrapping.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_FILTERS) idx = idx - NUM_FILTERS;
         if (!grant_found && elig[IW'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = IW'(idx);
         end
      end
   end

   // Flush scans for the lowest dirty register; it waits on that one even if a
   // higher dirty register is already unlocked, so releases leave in order.
   always_comb begin
      fl_found = 1'b0;
      fl_idx   = '0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
         if (!fl_found && dirty[k]) begin
            fl_found = 1'b1;
            fl_idx   = IW'(k);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      rdy_c      = '0;
      lane_issue = '0;
      lane_rel   = '0;
      vld_d      = 1'b0;
      frc_d      = '0;
      sel_d      = '0;
      rel_d      = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               lane_issue[grant_idx] = 1'b1;
               sel_d[grant_idx]      = 1'b1;
               ptr_d = (grant_idx == IW'(NUM_FILTERS - 1)) ? '0 : grant_idx + IW'(1);
               if (dirty[grant_idx] && (in_tag[grant_idx] != tag[grant_idx])) begin
                  // Particle changed under an open sum: close it first and
                  // leave the new fragment waiting (no ready).
                  lane_rel[grant_idx] = 1'b1;
                  rel_d               = 1'b1;
                  frc_d               = {tag[grant_idx], {FLOAT_STRUCT_WIDTH{1'b0}}};
               end else begin
                  rdy_c[grant_idx]    = 1'b1;
                  lane_rel[grant_idx] = bus.req_last[grant_idx];
                  vld_d               = 1'b1;
                  frc_d               = bus.req_frc[grant_idx];
                  rel_d               = bus.req_last[grant_idx];
               end
            end
            if (bus.flush_req) state_d = FLUSH;
         end
         FLUSH: begin
            if (fl_found) begin
               if (lock_zero[fl_idx]) begin
                  lane_issue[fl_idx] = 1'b1;
                  lane_rel[fl_idx]   = 1'b1;
                  sel_d[fl_idx]      = 1'b1;
                  rel_d              = 1'b1;
                  frc_d              = {tag[fl_idx], {FLOAT_STRUCT_WIDTH{1'b0}}};
               end
            end else if (&lock_zero) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            // Give the final release ACC_LATENCY cycles to drain.
            if (cnt_q == CW'(ACC_LATENCY - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         frc_q   <= '0;
         sel_q   <= '0;
         rel_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         frc_q   <= frc_d;
         sel_q   <= sel_d;
         rel_q   <= rel_d;
         done_q  <= done_d;
      end
   end

   // Grant is combinational; held off while reset is asserted.
   assign bus.req_ready           = rst ? '0 : rdy_c;
   assign bus.busy                = (state_q != IDLE);
   assign bus.flush_done          = done_q;
   assign bus.nb_frc_valid        = vld_q;
   assign bus.nb_frc              = frc_q;
   assign bus.nb_reg_sel          = sel_q;
   assign bus.nb_reg_release_flag = rel_q;
endmodule

// File: tb/tb_nb_frc_acc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nb_frc_acc_scheduler
//   Directed bench for nb_frc_acc_scheduler (NUM_FILTERS=4, ACC_LATENCY=3,
//   48-bit packets with a 16-bit tag above a 32-bit payload). Inputs change
//   1 time unit after the rising edge; everything is sampled on the falling
//   edge, so req_ready reflects this cycle's grant and the bus shows the
//   issue made in the previous cycle.
// ---------------------------------------------------------------------------
module tb_nb_frc_acc_scheduler;
   localparam int N   = 4;
   localparam int LAT = 3;
   localparam int PKT = 48;
   localparam int FLT = 32;
   localparam logic [PKT-1:0] Z = '0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nb_frc_acc_scheduler_if #(.NUM_FILTERS(N), .FRC_PKT_STRUCT_WIDTH(PKT)) bus ();

   nb_frc_acc_scheduler #(
      .NUM_FILTERS          (N),
      .ACC_LATENCY          (LAT),
      .FRC_PKT_STRUCT_WIDTH (PKT),
      .FLOAT_STRUCT_WIDTH   (FLT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   function automatic logic [PKT-1:0] pkt(input logic [15:0] t, input logic [31:0] pl);
      return {t, pl};
   endfunction

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   // One cycle: sample at the falling edge, then step past the rising edge.
   task automatic cyc(input string nm, input logic [N-1:0] rdy, input logic vld,
                      input logic [PKT-1:0] frc, input logic [N-1:0] sel,
                      input logic rel, input logic bsy, input logic fd);
      @(negedge clk);
      chk({nm, ".req_ready"},  64'(bus.req_ready),           64'(rdy));
      chk({nm, ".valid"},      64'(bus.nb_frc_valid),        64'(vld));
      chk({nm, ".nb_frc"},     64'(bus.nb_frc),              64'(frc));
      chk({nm, ".reg_sel"},    64'(bus.nb_reg_sel),          64'(sel));
      chk({nm, ".release"},    64'(bus.nb_reg_release_flag), 64'(rel));
      chk({nm, ".busy"},       64'(bus.busy),                64'(bsy));
      chk({nm, ".flush_done"}, 64'(bus.flush_done),          64'(fd));
      @(posedge clk); #1;
   endtask

   task automatic idle(input string nm, input logic [N-1:0] rdy, input logic bsy, input logic fd);
      cyc(nm, rdy, 1'b0, Z, '0, 1'b0, bsy, fd);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '1;
      bus.req_last  = '0;
      bus.req_frc   = '0;
      bus.flush_req = 1'b0;
      @(posedge clk); #1;
      // Requests are pending but reset holds ready low and the bus quiet.
      idle("reset", '0, 1'b0, 1'b0);
      rst           = 1'b0;
      bus.req_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- 1: single stream on filter 2 ----------------
      do_reset();
      bus.req_valid = 4'b0100;
      bus.req_frc[2] = pkt(16'h0015, 32'hA000_0001);
      idle("s1.c0", 4'b0100, 1'b0, 1'b0);
      bus.req_frc[2] = pkt(16'h0015, 32'hA000_0002);
      cyc("s1.c1", '0, 1'b1, pkt(16'h0015, 32'hA000_0001), 4'b0100, 1'b0, 1'b0, 1'b0);
      idle("s1.c2", '0, 1'b0, 1'b0);
      idle("s1.c3", '0, 1'b0, 1'b0);
      idle("s1.c4", 4'b0100, 1'b0, 1'b0);
      bus.req_frc[2] = pkt(16'h0015, 32'hA000_0003);
      bus.req_last   = 4'b0100;
      cyc("s1.c5", '0, 1'b1, pkt(16'h0015, 32'hA000_0002), 4'b0100, 1'b0, 1'b0, 1'b0);
      idle("s1.c6", '0, 1'b0, 1'b0);
      idle("s1.c7", '0, 1'b0, 1'b0);
      idle("s1.c8", 4'b0100, 1'b0, 1'b0);
      bus.req_valid = '0;
      bus.req_last  = '0;
      cyc("s1.c9", '0, 1'b1, pkt(16'h0015, 32'hA000_0003), 4'b0100, 1'b1, 1'b0, 1'b0);
      idle("s1.c10", '0, 1'b0, 1'b0);
      idle("s1.c11", '0, 1'b0, 1'b0);
      // Register 2 was released: a new tag is granted directly, no close.
      bus.req_valid  = 4'b0100;
      bus.req_last   = 4'b0100;
      bus.req_frc[2] = pkt(16'h0022, 32'hB000_0001);
      idle("s1.new", 4'b0100, 1'b0, 1'b0);
      bus.req_valid = '0;
      bus.req_last  = '0;
      cyc("s1.newout", '0, 1'b1, pkt(16'h0022, 32'hB000_0001), 4'b0100, 1'b1, 1'b0, 1'b0);

      // ---------------- 2: full contention ----------------
      do_reset();
      bus.req_valid = '1;
      for (int i = 0; i < N; i++) bus.req_frc[i] = pkt(16'h0030 + 16'(i), 32'h1000 + 32'(i));
      for (int k = 0; k < 8; k++) begin
         logic [N-1:0] er, es;
         int           pf;
         er = N'(1) << (k % N);
         if (k == 0) begin
            idle("rr", er, 1'b0, 1'b0);
         end else begin
            pf = (k - 1) % N;
            es = N'(1) << pf;
            cyc("rr", er, 1'b1, pkt(16'h0030 + 16'(pf), 32'h1000 + 32'(pf)), es, 1'b0, 1'b0, 1'b0);
         end
      end
      bus.req_valid = '0;
      cyc("rr.tail", '0, 1'b1, pkt(16'h0033, 32'h1003), 4'b1000, 1'b0, 1'b0, 1'b0);

      // ---------------- 3: implicit close on filter 1 ----------------
      do_reset();
      bus.req_valid  = 4'b0010;
      bus.req_frc[1] = pkt(16'h00A1, 32'hAAAA_0001);
      idle("ic.c0", 4'b0010, 1'b0, 1'b0);
      bus.req_frc[1] = pkt(16'h00B2, 32'hBBBB_0002);
      cyc("ic.c1", '0, 1'b1, pkt(16'h00A1, 32'hAAAA_0001), 4'b0010, 1'b0, 1'b0, 1'b0);
      idle("ic.c2", '0, 1'b0, 1'b0);
      idle("ic.c3", '0, 1'b0, 1'b0);
      idle("ic.close", '0, 1'b0, 1'b0);
      cyc("ic.rel", '0, 1'b0, pkt(16'h00A1, 32'h0), 4'b0010, 1'b1, 1'b0, 1'b0);
      idle("ic.c6", '0, 1'b0, 1'b0);
      idle("ic.c7", '0, 1'b0, 1'b0);
      idle("ic.accept", 4'b0010, 1'b0, 1'b0);
      bus.req_valid = '0;
      cyc("ic.out", '0, 1'b1, pkt(16'h00B2, 32'hBBBB_0002), 4'b0010, 1'b0, 1'b0, 1'b0);

      // ---------------- 4: flush with registers 0 and 3 open ----------------
      do_reset();
      bus.req_valid  = 4'b1001;
      bus.req_frc[0] = pkt(16'h00C0, 32'hC000_0000);
      bus.req_frc[3] = pkt(16'h00C3, 32'hC000_0003);
      idle("fl.c0", 4'b0001, 1'b0, 1'b0);
      bus.req_valid = 4'b1000;
      cyc("fl.c1", 4'b1000, 1'b1, pkt(16'h00C0, 32'hC000_0000), 4'b0001, 1'b0, 1'b0, 1'b0);
      bus.req_valid = '0;
      bus.flush_req = 1'b1;
      cyc("fl.c2", '0, 1'b1, pkt(16'h00C3, 32'hC000_0003), 4'b1000, 1'b0, 1'b0, 1'b0);
      // Clean filters keep requesting; nothing is granted while flushing.
      bus.flush_req  = 1'b0;
      bus.req_valid  = 4'b0110;
      bus.req_frc[1] = pkt(16'h0001, 32'h1);
      bus.req_frc[2] = pkt(16'h0002, 32'h2);
      idle("fl.wait0", '0, 1'b1, 1'b0);        // lock[0] still 1
      idle("fl.iss0", '0, 1'b1, 1'b0);         // release 0 issued
      cyc("fl.rel0", '0, 1'b0, pkt(16'h00C0, 32'h0), 4'b0001, 1'b1, 1'b1, 1'b0);
      cyc("fl.rel3", '0, 1'b0, pkt(16'h00C3, 32'h0), 4'b1000, 1'b1, 1'b1, 1'b0);
      // Locks drain (last reaches 0 three cycles later), then DONE waits LAT.
      for (int k = 0; k < 6; k++) idle("fl.drain", '0, 1'b1, 1'b0);
      bus.req_valid = '0;
      idle("fl.done", '0, 1'b0, 1'b1);
      idle("fl.after", '0, 1'b0, 1'b0);

      // ---------------- 5: empty flush ----------------
      do_reset();
      bus.flush_req = 1'b1;
      idle("ef.req", '0, 1'b0, 1'b0);
      bus.flush_req = 1'b0;
      idle("ef.flush", '0, 1'b1, 1'b0);
      for (int k = 0; k < LAT; k++) idle("ef.wait", '0, 1'b1, 1'b0);
      idle("ef.done", '0, 1'b0, 1'b1);
      idle("ef.after", '0, 1'b0, 1'b0);

      // ---------------- 6: reset during flush ----------------
      do_reset();
      bus.req_valid  = 4'b0001;
      bus.req_frc[0] = pkt(16'h00D0, 32'hD000_0000);
      idle("rf.c0", 4'b0001, 1'b0, 1'b0);
      bus.req_valid = '0;
      bus.flush_req = 1'b1;
      cyc("rf.c1", '0, 1'b1, pkt(16'h00D0, 32'hD000_0000), 4'b0001, 1'b0, 1'b0, 1'b0);
      bus.flush_req = 1'b0;
      idle("rf.flush", '0, 1'b1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) idle("rf.quiet", '0, 1'b0, 1'b0);
      // Dirty state was cleared: a new tag on filter 0 is granted directly.
      bus.req_valid  = 4'b0001;
      bus.req_last   = 4'b0001;
      bus.req_frc[0] = pkt(16'h00D9, 32'hD000_0009);
      idle("rf.new", 4'b0001, 1'b0, 1'b0);
      bus.req_valid = '0;
      bus.req_last  = '0;
      cyc("rf.newout", '0, 1'b1, pkt(16'h00D9, 32'hD000_0009), 4'b0001, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
